parking_slot_tracker: RTL

Parametrised N-slot parking occupancy and billing tracker. Replaces the fixed three-car enter/exit logic with one slot FSM per slot, per-slot entry timestamps and visit counters, wrap-safe duration billing, a running revenue total and explicit error reporting. Sits between the button/switch debouncers and the display/fee multiplexer. It consumes the free-running `timer_count` from the system timer.

---
 rtl/parking_slot_tracker_pkg.sv | 27 ++
 rtl/parking_slot_tracker_if.sv | 24 ++
 rtl/parking_fee_calc.sv | 32 +++
 rtl/parking_slot_tracker.sv | 118 +++++++++++
 4 files changed

// File: rtl/parking_slot_tracker_pkg.sv
// Shared types, default widths and saturating arithmetic for the parking slot tracker.
package parking_pkg;

  localparam int N_SLOTS_DEF = 3;
  localparam int TIME_W_DEF  = 10;
  localparam int CNT_W_DEF   = 10;
  localparam int COST_W_DEF  = 10;
  localparam int REV_W_DEF   = 16;
  localparam int RATE_DEF    = 1;
  localparam int FEE_CAP_DEF = 20;

  typedef enum logic {
    SLOT_FREE     = 1'b0,
    SLOT_OCCUPIED = 1'b1
  } slot_st_t;

  // Unsigned add clamped to 2^w-1; callers use w <= 32 and truncate the result.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/parking_slot_tracker_if.sv
// Request/fee bundle between the debouncers and the tracker.
interface parking_slot_tracker_if #(
  parameter int SEL_W  = 2,
  parameter int TIME_W = 10,
  parameter int COST_W = 10
);
  logic              car_enter;
  logic              car_exit;
  logic [SEL_W-1:0]  car_sel;
  logic [TIME_W-1:0] timer_count;
  logic [COST_W-1:0] current_cost;
  logic              fee_valid;
  logic              err;

  modport master (
    output car_enter, car_exit, car_sel, timer_count,
    input  current_cost, fee_valid, err
  );

  modport slave (
    input  car_enter, car_exit, car_sel, timer_count,
    output current_cost, fee_valid, err
  );
endinterface

// File: rtl/parking_fee_calc.sv
// Combinational fee: wrap-safe duration times RATE, saturated to COST_W bits.
// Optional PARK_FEE_CAP_EN additionally limits the fee to FEE_CAP.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int TIME_W  = TIME_W_DEF,
  parameter int COST_W  = COST_W_DEF,
  parameter int RATE    = RATE_DEF,
  parameter int FEE_CAP = FEE_CAP_DEF
) (
  input  logic [TIME_W-1:0] enter_time,
  input  logic [TIME_W-1:0] now,
  output logic [COST_W-1:0] fee
);
  localparam int PROD_W = TIME_W + 32;

  logic [TIME_W-1:0] duration;
  logic [PROD_W-1:0] product;
  logic [COST_W-1:0] fee_sat;

  always_comb begin
    // modulo-2^TIME_W subtraction keeps the duration correct across timer wrap
    duration = now - enter_time;
    product  = PROD_W'(duration) * PROD_W'($unsigned(32'(RATE)));
    fee_sat  = (|product[PROD_W-1:COST_W]) ? '1 : product[COST_W-1:0];
`ifdef PARK_FEE_CAP_EN
    fee = (fee_sat > COST_W'(FEE_CAP)) ? COST_W'(FEE_CAP) : fee_sat;
`else
    fee = fee_sat;
`endif
  end
endmodule

// File: rtl/parking_slot_tracker.sv
// N-slot parking occupancy and billing tracker; PARK_FEE_CAP_EN enables the per-visit fee cap.
//   state         | meaning
//   SLOT_FREE     | slot empty, accepts an enter
//   SLOT_OCCUPIED | car parked, accepts an exit which bills the visit
module parking_slot_tracker
  import parking_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int SEL_W   = $clog2(N_SLOTS),
  parameter int TIME_W  = TIME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int COST_W  = COST_W_DEF,
  parameter int REV_W   = REV_W_DEF,
  parameter int RATE    = RATE_DEF,
  parameter int FEE_CAP = FEE_CAP_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  parking_slot_tracker_if.slave     bus,
  output logic [N_SLOTS-1:0]        slot_state,
  output logic [N_SLOTS*TIME_W-1:0] slot_enter_time,
  output logic [N_SLOTS*CNT_W-1:0]  slot_count,
  output logic [N_SLOTS*COST_W-1:0] slot_cost,
  output logic [REV_W-1:0]          revenue,
  output logic [SEL_W:0]            free_slots,
  output logic                      full
);
  logic              sel_ok, sel_occ, enter_ok, exit_ok, req_err;
  logic [TIME_W-1:0] sel_enter_time;
  logic [COST_W-1:0] fee;
  logic [SEL_W:0]    occ_cnt;

  always_comb begin
    sel_ok         = 32'(bus.car_sel) < 32'(N_SLOTS);
    sel_occ        = 1'b0;
    sel_enter_time = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (bus.car_sel == SEL_W'(i)) begin
        sel_occ        = slot_state[i];
        sel_enter_time = slot_enter_time[i*TIME_W +: TIME_W];
      end
    end
    enter_ok = bus.car_enter && !bus.car_exit && sel_ok && !sel_occ;
    exit_ok  = bus.car_exit && !bus.car_enter && sel_ok && sel_occ;
    req_err  = (bus.car_enter || bus.car_exit) && !enter_ok && !exit_ok;
  end

  parking_fee_calc #(
    .TIME_W (TIME_W),
    .COST_W (COST_W),
    .RATE   (RATE),
    .FEE_CAP(FEE_CAP)
  ) u_fee_calc (
    .enter_time(sel_enter_time),
    .now       (bus.timer_count),
    .fee       (fee)
  );

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    slot_st_t          st;
    logic [TIME_W-1:0] enter_time_q;
    logic [CNT_W-1:0]  count_q;
    logic [COST_W-1:0] cost_q;
    logic              hit;

    assign hit = (bus.car_sel == SEL_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        st           <= SLOT_FREE;
        enter_time_q <= '0;
        count_q      <= '0;
        cost_q       <= '0;
      end else begin
        case (st)
          SLOT_FREE: if (enter_ok && hit) begin
            st           <= SLOT_OCCUPIED;
            enter_time_q <= bus.timer_count;
            count_q      <= CNT_W'(sat_add(32'(count_q), 32'd1, CNT_W));
          end
          SLOT_OCCUPIED: if (exit_ok && hit) begin
            st     <= SLOT_FREE;
            cost_q <= fee;
          end
        endcase
      end
    end

    assign slot_state[i]                        = (st == SLOT_OCCUPIED);
    assign slot_enter_time[i*TIME_W +: TIME_W]  = enter_time_q;
    assign slot_count[i*CNT_W +: CNT_W]         = count_q;
    assign slot_cost[i*COST_W +: COST_W]        = cost_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.current_cost <= '0;
      bus.fee_valid    <= 1'b0;
      bus.err          <= 1'b0;
      revenue          <= '0;
    end else begin
      bus.fee_valid <= exit_ok;
      bus.err       <= req_err;
      if (exit_ok) begin
        bus.current_cost <= fee;
        revenue          <= REV_W'(sat_add(32'(revenue), 32'(fee), REV_W));
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) occ_cnt += (SEL_W+1)'(slot_state[i]);
  end

  assign free_slots = (SEL_W+1)'(N_SLOTS) - occ_cnt;
  assign full       = (free_slots == '0);
endmodule
